linear_classifier: RTL
======================

Name: linear_classifier

Overview:
- Final fully-connected stage of the MobileNetV3 classifier head; sits directly downstream of the 1D batch-norm stage.
- Consumes the normalised FEATURES-wide vector and computes CLASSES logits: y[c] = sum_f x[f]*W[c][f] + b[c].
- Computes with one sequential MAC. Weights stream from an external synchronous ROM at one weight per cycle, addressed by this block.

Parameters:
- WIDTH, 16, data/weight/bias/output word width (signed fixed point).
- FRAC, 8, fractional bits of all operands.
- FEATURES, 1280, input vector length.
- CLASSES, 15, number of output logits.
- ACC_WIDTH, 44, signed accumulator width (must be >= 2*WIDTH+$clog2(FEATURES)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- en  in  1  global advance enable.
- data_in  in  WIDTH x FEATURES  signed feature vector.
- valid_in  in  1  data_in valid; sampled only when ready_out==1.
- ready_out  out  1  high in IDLE.
- w_rd  out  1  weight ROM read strobe.
- w_addr  out  $clog2(CLASSES*FEATURES)  ROM address = c*FEATURES+f.
- w_data  in  WIDTH  signed weight, valid the cycle after w_rd (latency 1).
- bias  in  WIDTH x CLASSES  signed biases, held static.
- data_out  out  WIDTH x CLASSES  signed logits.
- valid_out  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE; all counters and the accumulator cleared.
  - data_out all 0; valid_out=0; w_rd=0; ready_out=1.
  - Any in-flight ROM read is discarded.
  - Reset mid-job aborts the job.
- States:
  - IDLE -> MAC: on en && valid_in. data_in is latched into an internal buffer; class c=0, feature f=0. Job start = cycle T.
  - MAC: each en cycle, w_rd=1 and w_addr=c*FEATURES+f; f increments. After f==FEATURES-1 is issued -> DRAIN.
  - DRAIN: one cycle; no read; the last returned weight is accumulated.
  - WRITE: data_out[c] <= sat(acc>>>FRAC + bias[c]); acc cleared. If c==CLASSES-1 -> DONE, else c++, f=0, -> MAC.
  - DONE: valid_out=1 for exactly this cycle -> IDLE.
- Read pipeline:
  - A 1-cycle delayed read-valid flag plus delayed feature index.
  - acc += buf[f_d]*w_data (full 2*WIDTH product, sign-extended to ACC_WIDTH).
  - The returned weight is accumulated even if en drops that cycle.
- en==0:
  - state, counters and outputs freeze; w_rd=0.
  - Resuming yields results identical to an unstalled run.
- Latency: valid_out is high at cycle T+CLASSES*(FEATURES+2)+1 when en is held high.
- Arithmetic:
  - Shift is arithmetic.
  - Bias is sign-extended before the add.
  - The result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap.
- Output holding: data_out holds its values until overwritten by the next job's WRITEs.
- Boundary cases:
  - valid_in while ready_out==0 is ignored (no queueing).
  - valid_in in the DONE cycle is ignored.
  - A new job may be accepted the cycle after DONE.

Optional Feature:
- Macro: LINEAR_CLASSIFIER_ARGMAX_EN.
- When defined:
  - Adds output class_idx ($clog2(CLASSES) bits), the index of the largest saturated logit.
  - Updated with a running compare during WRITE; ties resolve to the lowest index.
  - Valid with valid_out; reset value 0.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan (directed tests use FEATURES=4, CLASSES=3 unless noted):
- Reset: rst=0 for 2 cycles -> data_out all 0, valid_out=0, w_rd=0, ready_out=1.
- Basic job: data all 256 (1.0), weights all 128 (0.5), bias 0, valid_in at T -> each logit 512; valid_out only at T+19; w_addr sequence 0..11.
- Saturation: data 32767, weights 32767, bias 32767 -> logits 32767. Same with weights -32768 and bias -32768 -> logits -32768.
- Stall: en=0 for 5 cycles mid-MAC of class 1 (including the cycle after a w_rd) -> logits equal the basic job; valid_out at T+24.
- Busy/abort:
  - valid_in pulsed during MAC -> ignored; one valid_out only.
  - rst=0 mid-job -> IDLE with zeroed outputs; the following job returns correct logits.
- Argmax (macro defined): logits -256, 512, 512 -> class_idx=1. All -32768 -> class_idx=0.

Source files
------------

// File: rtl/linear_classifier.sv
// -----------------------------------------------------------------------------
// linear_classifier
//
// Final fully-connected stage of the MobileNetV3 classifier head. It takes the
// normalised feature vector from the 1D batch-norm stage and produces CLASSES
// logits:
//
//    y[c] = sat( (sum_f x[f]*W[c][f]) >>> FRAC + b[c] )
//
// A single sequential MAC does the work. Weights stream from an external
// synchronous ROM with one-cycle read latency, one weight per cycle. The
// address is c*FEATURES+f.
//
// Per class the schedule is FEATURES MAC cycles, one DRAIN cycle and one WRITE
// cycle. A DONE cycle follows the last class. With en held high, valid_out
// rises CLASSES*(FEATURES+2)+1 cycles after the accepting cycle.
//
// Ports
//    clk        clock
//    rst        synchronous reset, active low
//    en         global advance enable. When low, state, counters and outputs
//               freeze and no ROM read is issued.
//    data_in    FEATURES x WIDTH signed feature vector, latched on accept
//    valid_in   data_in valid; sampled only while ready_out is high
//    ready_out  high in IDLE
//    w_rd       weight ROM read strobe
//    w_addr     weight ROM address, c*FEATURES+f
//    w_data     signed weight, valid the cycle after w_rd
//    bias       CLASSES x WIDTH signed biases, held static
//    data_out   CLASSES x WIDTH signed saturated logits, held until rewritten
//    valid_out  one-cycle completion pulse
//    class_idx  (LINEAR_CLASSIFIER_ARGMAX_EN only) index of the largest logit;
//               ties resolve to the lowest index
//
// Optional feature macro: LINEAR_CLASSIFIER_ARGMAX_EN
// -----------------------------------------------------------------------------
module linear_classifier #(
   parameter int WIDTH     = 16,
   parameter int FRAC      = 8,
   parameter int FEATURES  = 1280,
   parameter int CLASSES   = 15,
   parameter int ACC_WIDTH = 44,
   localparam int AW       = $clog2(CLASSES * FEATURES),
   localparam int CW       = (CLASSES > 1) ? $clog2(CLASSES) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic signed [FEATURES-1:0][WIDTH-1:0] data_in,
   input  logic                                 valid_in,
   output logic                                 ready_out,
   output logic                                 w_rd,
   output logic        [AW-1:0]                 w_addr,
   input  logic signed [WIDTH-1:0]              w_data,
   input  logic signed [CLASSES-1:0][WIDTH-1:0] bias,
   output logic signed [CLASSES-1:0][WIDTH-1:0] data_out,
   output logic                                 valid_out
`ifdef LINEAR_CLASSIFIER_ARGMAX_EN
   ,
   output logic        [CW-1:0]                 class_idx
`endif
);

   localparam int FW = (FEATURES > 1) ? $clog2(FEATURES) : 1;
   localparam int PW = 2 * WIDTH;

   localparam logic [FW-1:0] F_LAST = FW'(FEATURES - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CLASSES - 1);

   localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [FW-1:0] f_q, f_d;
   logic [CW-1:0] c_q, c_d;

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

   logic signed [CLASSES-1:0][WIDTH-1:0] out_q, out_d;

   // Read pipeline: the read-valid flag and feature index delayed by the ROM
   // latency, so the returned weight is paired with the right feature.
   logic          rd_vld_q;
   logic [FW-1:0] rd_f_q;

   logic signed [WIDTH-1:0] fbuf_q [FEATURES];
   logic                    load_en;

   logic signed [WIDTH-1:0]     x_rd;
   logic signed [PW-1:0]        prod;
   logic signed [WIDTH-1:0]     bias_c;
   logic signed [ACC_WIDTH-1:0] sum_w;
   logic signed [WIDTH-1:0]     sat_val;

`ifdef LINEAR_CLASSIFIER_ARGMAX_EN
   logic signed [WIDTH-1:0] best_q, best_d;
   logic        [CW-1:0]    idx_q, idx_d;
`endif

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------

   assign x_rd = fbuf_q[rd_f_q];

   // Full-width signed product; the sized casts sign-extend both operands.
   assign prod = PW'(x_rd) * PW'(w_data);

   assign bias_c = bias[c_q];

   // Arithmetic shift back to FRAC fractional bits, then add the bias
   // sign-extended to the accumulator width and clamp to the output range.
   always_comb begin
      sum_w = (acc_q >>> FRAC) + ACC_WIDTH'(bias_c);
      if (sum_w > ACC_WIDTH'(W_MAX)) begin
         sat_val = W_MAX;
      end else if (sum_w < ACC_WIDTH'(W_MIN)) begin
         sat_val = W_MIN;
      end else begin
         sat_val = sum_w[WIDTH-1:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------

   assign ready_out = (state_q == S_IDLE);
   assign w_rd      = (state_q == S_MAC) && en;
   assign w_addr    = AW'(c_q) * AW'(FEATURES) + AW'(f_q);

   // Gated by en so that a stall landing on DONE cannot stretch the pulse.
   assign valid_out = (state_q == S_DONE) && en;
   assign data_out  = out_q;

`ifdef LINEAR_CLASSIFIER_ARGMAX_EN
   assign class_idx = idx_q;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------

   always_comb begin
      // NOTE: every always_comb target is given a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d = state_q;
      f_d     = f_q;
      c_d     = c_q;
      acc_d   = acc_q;
      out_d   = out_q;
      load_en = 1'b0;
`ifdef LINEAR_CLASSIFIER_ARGMAX_EN
      best_d  = best_q;
      idx_d   = idx_q;
`endif

      // A returned weight is accumulated even when en is low. Otherwise a
      // stall in the cycle after a read would lose that weight.
      if (rd_vld_q) begin
         acc_d = acc_q + ACC_WIDTH'(prod);
      end

      if (en) begin
         unique case (state_q)
            S_IDLE: begin
               if (valid_in) begin
                  load_en = 1'b1;
                  f_d     = '0;
                  c_d     = '0;
                  acc_d   = '0;
                  state_d = S_MAC;
               end
            end

            S_MAC: begin
               if (f_q == F_LAST) begin
                  state_d = S_DRAIN;
               end else begin
                  f_d = f_q + FW'(1);
               end
            end

            // The last weight of the class arrives here and is accumulated above.
            S_DRAIN: begin
               state_d = S_WRITE;
            end

            S_WRITE: begin
               out_d[c_q] = sat_val;
               acc_d      = '0;
`ifdef LINEAR_CLASSIFIER_ARGMAX_EN
               // Class 0 always seeds the running maximum. A later class wins
               // only on a strictly larger value, so ties keep the lower index.
               if ((c_q == '0) || (sat_val > best_q)) begin
                  best_d = sat_val;
                  idx_d  = c_q;
               end
`endif
               if (c_q == C_LAST) begin
                  state_d = S_DONE;
               end else begin
                  c_d     = c_q + CW'(1);
                  f_d     = '0;
                  state_d = S_MAC;
               end
            end

            S_DONE: begin
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         f_q      <= '0;
         c_q      <= '0;
         acc_q    <= '0;
         out_q    <= '0;
         rd_vld_q <= 1'b0;  // discards any in-flight ROM read
         rd_f_q   <= '0;
`ifdef LINEAR_CLASSIFIER_ARGMAX_EN
         best_q   <= '0;
         idx_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         f_q      <= f_d;
         c_q      <= c_d;
         acc_q    <= acc_d;
         out_q    <= out_d;
         rd_vld_q <= w_rd;
         rd_f_q   <= f_q;
`ifdef LINEAR_CLASSIFIER_ARGMAX_EN
         best_q   <= best_d;
         idx_q    <= idx_d;
`endif
      end
   end

   // NOTE: the feature buffer is deliberately not reset. It is only read after
   // a job has loaded it, and leaving it unreset keeps it a plain register file.
   always_ff @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < FEATURES; i++) begin
            fbuf_q[i] <= data_in[i];
         end
      end
   end

endmodule
